// File: rtl/gpio_tone_gen_if.sv
// Command/status bundle for gpio_tone_gen: master issues tone commands, slave returns pin/busy/done.
// Latency: none (wires only). Backpressure: none, the slave accepts one command every cycle.
// GPIO_TONE_IRQ_EN adds the irq output and irq_clr write-1-to-clear input.
interface gpio_tone_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int DUR_W  = 16
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_half;
    logic [DUR_W-1:0]  wr_dur;
    logic [NUM_CH-1:0] pin;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
`ifdef GPIO_TONE_IRQ_EN
    logic              irq;
    logic [NUM_CH-1:0] irq_clr;
`endif

    modport master (
        output wr_en, wr_ch, wr_half, wr_dur,
`ifdef GPIO_TONE_IRQ_EN
        output irq_clr,
        input  irq,
`endif
        input  pin, busy, done
    );

    modport slave (
        input  wr_en, wr_ch, wr_half, wr_dur,
`ifdef GPIO_TONE_IRQ_EN
        input  irq_clr,
        output irq,
`endif
        output pin, busy, done
    );
endinterface

// File: rtl/gpio_tone_gen.sv
// Multi-channel square-wave tone generator; each channel plays half-period/duration tones.
// Latency: command in cycle t drives pin/busy at t+1; done and irq (GPIO_TONE_IRQ_EN) are registered.
// Backpressure: none, every channel accepts a command every cycle; out-of-range wr_ch is dropped.
module gpio_tone_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int DUR_W  = 16
) (
    input  logic            clk,
    input  logic            resetn,
    gpio_tone_gen_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } tone_st_t;

    logic [NUM_CH-1:0] pin_w;
    logic [NUM_CH-1:0] busy_w;
    logic [NUM_CH-1:0] done_w;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            tone_st_t         st_q, st_n;
            logic [CNT_W-1:0] half_q, half_n;
            logic [CNT_W-1:0] cnt_q, cnt_n;
            logic [DUR_W-1:0] dur_q, dur_n;
            logic             done_n;
            logic             pin_q, busy_q, done_q;
            logic             cmd;

            // Values of wr_ch >= NUM_CH never match any generated channel index.
            assign cmd = bus.wr_en && (bus.wr_ch == CH_W'(i));

            always_comb begin
                st_n   = st_q;
                half_n = half_q;
                cnt_n  = cnt_q;
                dur_n  = dur_q;
                done_n = 1'b0;
                if (cmd) begin
                    cnt_n = '0;
                    if (bus.wr_half == '0) begin
                        st_n  = ST_IDLE;
                        dur_n = '0;
                    end else begin
                        st_n   = ST_HIGH;
                        half_n = bus.wr_half;
                        dur_n  = bus.wr_dur;
                    end
                end else if (st_q != ST_IDLE) begin
                    if (cnt_q == half_q - CNT_W'(1)) begin
                        cnt_n = '0;
                        if (st_q == ST_HIGH) begin
                            st_n = ST_LOW;
                        end else if (dur_q == DUR_W'(1)) begin
                            st_n   = ST_IDLE;
                            dur_n  = '0;
                            done_n = 1'b1;
                        end else begin
                            // dur_q == 0 means continuous: hold it at zero.
                            st_n = ST_HIGH;
                            if (dur_q != '0) dur_n = dur_q - DUR_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    st_q   <= ST_IDLE;
                    half_q <= '0;
                    cnt_q  <= '0;
                    dur_q  <= '0;
                    pin_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end else begin
                    st_q   <= st_n;
                    half_q <= half_n;
                    cnt_q  <= cnt_n;
                    dur_q  <= dur_n;
                    pin_q  <= (st_n == ST_HIGH);
                    busy_q <= (st_n != ST_IDLE);
                    done_q <= done_n;
                end
            end

            assign pin_w[i]  = pin_q;
            assign busy_w[i] = busy_q;
            assign done_w[i] = done_q;
        end
    endgenerate

    assign bus.pin  = pin_w;
    assign bus.busy = busy_w;
    assign bus.done = done_w;

`ifdef GPIO_TONE_IRQ_EN
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_n;
    logic              irq_q;

    // A new done beats a simultaneous clear of the same bit.
    assign pend_n = (pend_q & ~bus.irq_clr) | done_w;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_n;
            irq_q  <= |pend_n;
        end
    end

    assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_gpio_tone_gen.sv
// Directed bench for gpio_tone_gen: table of single-tone vectors plus hand-written corner sequences.
module tb_gpio_tone_gen;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 24;
    localparam int DUR_W  = 16;
    localparam int CH_W   = 3;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;

    gpio_tone_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DUR_W(DUR_W)) ifc ();

    gpio_tone_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          half;
        int          dur;
        logic [15:0] pin;
        logic [15:0] busy;
        logic [15:0] done;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmd(input int ch, input int half, input int dur);
        ifc.wr_en   = 1'b1;
        ifc.wr_ch   = CH_W'(ch);
        ifc.wr_half = CNT_W'(half);
        ifc.wr_dur  = DUR_W'(dur);
    endtask

    task automatic idle_cmd();
        ifc.wr_en   = 1'b0;
        ifc.wr_ch   = '0;
        ifc.wr_half = '0;
        ifc.wr_dur  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_cmd();
    endtask

    vec_t vecs[5];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        idle_cmd();
`ifdef GPIO_TONE_IRQ_EN
        ifc.irq_clr = '0;
`endif
        vecs[0] = '{ch: 0, half: 3, dur: 2, pin: 16'hE380, busy: 16'hFFF0, done: 16'h0008};
        vecs[1] = '{ch: 1, half: 1, dur: 3, pin: 16'hA800, busy: 16'hFC00, done: 16'h0200};
        vecs[2] = '{ch: 4, half: 2, dur: 1, pin: 16'hC000, busy: 16'hF000, done: 16'h0800};
        vecs[3] = '{ch: 2, half: 1, dur: 0, pin: 16'hAAAA, busy: 16'hFFFF, done: 16'h0000};
        vecs[4] = '{ch: 3, half: 4, dur: 1, pin: 16'hF000, busy: 16'hFF00, done: 16'h0080};

        // Reset state, then 10 idle cycles
        #12;
        chk("reset_pin", 32'(ifc.pin), 32'h0);
        chk("reset_busy", 32'(ifc.busy), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_pin", 32'(ifc.pin), 32'h0);
        chk("idle_busy", 32'(ifc.busy), 32'h0);
        chk("idle_done", 32'(ifc.done), 32'h0);
`ifdef GPIO_TONE_IRQ_EN
        chk("idle_irq", 32'(ifc.irq), 32'h0);
`endif
        @(posedge clk);
        #1;

        // Table-driven single-channel tones, stopped afterwards
        for (int v = 0; v < 5; v++) begin
            cmd(vecs[v].ch, vecs[v].half, vecs[v].dur);
            next_cycle();
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_pin[%0d]", v, k), 32'(ifc.pin[vecs[v].ch]), 32'(vecs[v].pin[15-k]));
                chk($sformatf("vec%0d_busy[%0d]", v, k), 32'(ifc.busy[vecs[v].ch]), 32'(vecs[v].busy[15-k]));
                chk($sformatf("vec%0d_done[%0d]", v, k), 32'(ifc.done[vecs[v].ch]), 32'(vecs[v].done[15-k]));
                next_cycle();
            end
            cmd(vecs[v].ch, 0, 0);
            next_cycle();
            @(negedge clk);
            chk($sformatf("vec%0d_stop_busy", v), 32'(ifc.busy), 32'h0);
            chk($sformatf("vec%0d_stop_done", v), 32'(ifc.done), 32'h0);
            @(posedge clk);
            #1;
        end

        // Continuous half=1 on ch1 for 50 cycles, then stop
        cmd(1, 1, 0);
        next_cycle();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk($sformatf("cont_pin1[%0d]", k), 32'(ifc.pin[1]), 32'((k % 2) == 0));
            chk($sformatf("cont_done1[%0d]", k), 32'(ifc.done[1]), 32'h0);
            next_cycle();
        end
        cmd(1, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("stop_pin1", 32'(ifc.pin[1]), 32'h0);
        chk("stop_busy1", 32'(ifc.busy[1]), 32'h0);
        chk("stop_done1", 32'(ifc.done[1]), 32'h0);
        @(posedge clk);
        #1;

        // Retrigger ch2 mid-LOW while ch0 plays continuously
        cmd(0, 3, 0);
        next_cycle();
        cmd(2, 5, 4);
        @(negedge clk);
        chk("conc_pin0_first", 32'(ifc.pin[0]), 32'h1);
        next_cycle();
        begin
            logic [15:0] p2, b2, d2;
            p2 = 16'hF980;
            b2 = 16'hFFE0;
            d2 = 16'h0010;
            for (int j = 0; j < 14; j++) begin
                if (j == 6) cmd(2, 2, 1);
                @(negedge clk);
                chk($sformatf("retrig_pin2[%0d]", j), 32'(ifc.pin[2]), 32'(p2[15-j]));
                chk($sformatf("retrig_busy2[%0d]", j), 32'(ifc.busy[2]), 32'(b2[15-j]));
                chk($sformatf("retrig_done2[%0d]", j), 32'(ifc.done[2]), 32'(d2[15-j]));
                chk($sformatf("conc_pin0[%0d]", j), 32'(ifc.pin[0]), 32'(((j + 1) % 6) < 3));
                chk($sformatf("conc_busy0[%0d]", j), 32'(ifc.busy[0]), 32'h1);
                next_cycle();
            end
        end
        cmd(0, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("conc_stop_busy", 32'(ifc.busy), 32'h0);
        @(posedge clk);
        #1;

        // Out-of-range channel is ignored
        cmd(NUM_CH, 2, 1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("oor_busy[%0d]", k), 32'(ifc.busy), 32'h0);
            chk($sformatf("oor_pin[%0d]", k), 32'(ifc.pin), 32'h0);
            next_cycle();
        end

        // Command in the same cycle as natural completion wins
        cmd(4, 1, 1);
        next_cycle();
        @(negedge clk);
        chk("coin_pin4_h", 32'(ifc.pin[4]), 32'h1);
        next_cycle();
        cmd(4, 2, 1);
        @(negedge clk);
        chk("coin_pin4_l", 32'(ifc.pin[4]), 32'h0);
        next_cycle();
        for (int j = 2; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("coin_pin4[%0d]", j), 32'(ifc.pin[4]), 32'(j < 4));
            chk($sformatf("coin_busy4[%0d]", j), 32'(ifc.busy[4]), 32'(j < 6));
            chk($sformatf("coin_done4[%0d]", j), 32'(ifc.done[4]), 32'(j == 6));
            next_cycle();
        end

`ifdef GPIO_TONE_IRQ_EN
        // Pending/irq: set, set-beats-clear, clear alone
        ifc.irq_clr = '1;
        next_cycle();
        ifc.irq_clr = '0;
        @(negedge clk);
        chk("irq_cleared", 32'(ifc.irq), 32'h0);
        @(posedge clk);
        #1;
        cmd(3, 1, 1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("irq_a_done3[%0d]", k), 32'(ifc.done[3]), 32'(k == 2));
            chk($sformatf("irq_a_irq[%0d]", k), 32'(ifc.irq), 32'(k == 3));
            next_cycle();
        end
        cmd(3, 1, 1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            ifc.irq_clr = (k == 2) ? 5'b01000 : 5'b00000;
            @(negedge clk);
            chk($sformatf("irq_b_done3[%0d]", k), 32'(ifc.done[3]), 32'(k == 2));
            chk($sformatf("irq_b_irq[%0d]", k), 32'(ifc.irq), 32'h1);
            next_cycle();
        end
        ifc.irq_clr = 5'b01000;
        next_cycle();
        ifc.irq_clr = '0;
        @(negedge clk);
        chk("irq_clear_alone", 32'(ifc.irq), 32'h0);
        @(posedge clk);
        #1;
`endif

        // Asynchronous reset in the middle of a tone
        cmd(0, 3, 0);
        next_cycle();
        @(negedge clk);
        chk("pre_rst_pin0", 32'(ifc.pin[0]), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_pin", 32'(ifc.pin), 32'h0);
        chk("async_rst_busy", 32'(ifc.busy), 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(ifc.busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
